// File: rtl/restoring_divider.sv
// rtl/restoring_divider.sv - sequential restoring divider, one quotient bit per cycle
// Define SIGNED_DIV_EN for two's-complement operands with sign correction in FIX.
module restoring_divider #(
   parameter int BUS_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [BUS_WIDTH-1:0] inbus,
   input  logic                 beginsig,
   input  logic                 locksig,
   output logic [BUS_WIDTH-1:0] outbus,
   output logic                 endsig,
   output logic                 busy,
   output logic                 divzero
);
   localparam int CW = $clog2(BUS_WIDTH + 1);
   localparam logic [CW-1:0] ITERS = CW'(BUS_WIDTH);

   typedef enum logic [2:0] {S_IDLE, S_LOAD_M, S_ITER, S_FIX, S_OUT_Q, S_OUT_R} state_t;

   state_t               r_state;
   logic [BUS_WIDTH-1:0] r_a;
   logic [BUS_WIDTH-1:0] r_q;
   logic [BUS_WIDTH-1:0] r_m;
   logic [BUS_WIDTH-1:0] r_outbus;
   logic [CW-1:0]        r_cnt;
   logic                 r_endsig;
   logic                 r_busy;
   logic                 r_divzero;
`ifdef SIGNED_DIV_EN
   logic                 r_neg_q;
   logic                 r_neg_r;
`endif

   logic [BUS_WIDTH:0]   w_sh_a;
   logic [BUS_WIDTH:0]   w_diff;
   logic                 w_ge;
   logic [BUS_WIDTH-1:0] w_dvd_mag;
   logic [BUS_WIDTH-1:0] w_dvs_mag;
   logic [BUS_WIDTH-1:0] w_fix_q;
   logic [BUS_WIDTH-1:0] w_fix_a;

   // The trial difference spans -M..M-1, so bit BUS_WIDTH is its sign.
   assign w_sh_a = {r_a, r_q[BUS_WIDTH-1]};
   assign w_diff = w_sh_a - {1'b0, r_m};
   assign w_ge   = ~w_diff[BUS_WIDTH];

   always_comb begin
      w_dvd_mag = r_q;
      w_dvs_mag = inbus;
      w_fix_q   = r_q;
      w_fix_a   = r_a;
`ifdef SIGNED_DIV_EN
      if (r_q[BUS_WIDTH-1])   w_dvd_mag = ~r_q + 1'b1;
      if (inbus[BUS_WIDTH-1]) w_dvs_mag = ~inbus + 1'b1;
      if (r_neg_q)            w_fix_q   = ~r_q + 1'b1;
      if (r_neg_r)            w_fix_a   = ~r_a + 1'b1;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_a       <= '0;
         r_q       <= '0;
         r_m       <= '0;
         r_cnt     <= '0;
         r_outbus  <= '0;
         r_endsig  <= 1'b0;
         r_busy    <= 1'b0;
         r_divzero <= 1'b0;
`ifdef SIGNED_DIV_EN
         r_neg_q   <= 1'b0;
         r_neg_r   <= 1'b0;
`endif
      end else if (!locksig) begin
         case (r_state)
            S_IDLE: begin
               if (beginsig) begin
                  r_q     <= inbus;
                  r_a     <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_LOAD_M;
               end
            end
            S_LOAD_M: begin
               r_cnt <= ITERS;
               if (inbus == '0) begin
                  r_m       <= '0;
                  r_q       <= '1;
                  r_a       <= r_q;
                  r_divzero <= 1'b1;
                  r_outbus  <= '1;
                  r_state   <= S_OUT_Q;
               end else begin
                  r_m     <= w_dvs_mag;
                  r_q     <= w_dvd_mag;
`ifdef SIGNED_DIV_EN
                  r_neg_q <= r_q[BUS_WIDTH-1] ^ inbus[BUS_WIDTH-1];
                  r_neg_r <= r_q[BUS_WIDTH-1];
`endif
                  r_state <= S_ITER;
               end
            end
            S_ITER: begin
               r_a   <= w_ge ? w_diff[BUS_WIDTH-1:0] : w_sh_a[BUS_WIDTH-1:0];
               r_q   <= {r_q[BUS_WIDTH-2:0], w_ge};
               r_cnt <= r_cnt - CW'(1);
               if (r_cnt == CW'(1)) r_state <= S_FIX;
            end
            S_FIX: begin
               r_q      <= w_fix_q;
               r_a      <= w_fix_a;
               r_outbus <= w_fix_q;
               r_state  <= S_OUT_Q;
            end
            S_OUT_Q: begin
               r_outbus <= r_a;
               r_endsig <= 1'b1;
               r_state  <= S_OUT_R;
            end
            S_OUT_R: begin
               r_outbus  <= '0;
               r_endsig  <= 1'b0;
               r_busy    <= 1'b0;
               r_divzero <= 1'b0;
               r_state   <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign outbus  = r_outbus;
   assign endsig  = r_endsig;
   assign busy    = r_busy;
   assign divzero = r_divzero;
endmodule

// File: doc/restoring_divider.md
Name: restoring_divider

Overview:
- Sequential restoring integer divider; the inverse datapath to the team's Booth multiplier.
- Uses the same bus-style handshake: operands in on `inbus`, results out on `outbus`, start on `beginsig`, stall on `locksig`, completion on `endsig`.
- Takes dividend and divisor in two consecutive accepted beats and computes one quotient bit per cycle.
- Returns quotient, then remainder, on `outbus` in two consecutive beats.

Parameters:
- BUS_WIDTH, 8, operand/result width in bits (minimum 2); the iteration counter width is derived internally as clog2(BUS_WIDTH+1).

Ports:
- clk  input  1  single clock; everything is rising-edge.
- rst  input  1  synchronous, active-high reset.
- inbus  input  BUS_WIDTH  operand bus: dividend on the start beat, divisor on the next accepted beat.
- beginsig  input  1  start request, sampled only in IDLE.
- locksig  input  1  stall: while high, all state holds.
- outbus  output  BUS_WIDTH  quotient in OUT_Q, remainder in OUT_R, 0 otherwise.
- endsig  output  1  high for exactly the OUT_R beat.
- busy  output  1  high in every state except IDLE.
- divzero  output  1  high in OUT_Q and OUT_R when the divisor was 0.

Behaviour:
- Reset: rst=1 at any edge (including mid-operation) forces:
  - state to IDLE
  - outbus=0, endsig=0, busy=0, divzero=0
  - internal A, Q, M and counter to 0.
- State IDLE:
  - If beginsig=1 and locksig=0: capture inbus as the dividend into Q, clear A, go to LOAD_M.
  - Otherwise stay in IDLE.
- State LOAD_M:
  - Capture inbus as the divisor into M and load counter=BUS_WIDTH.
  - If divisor==0: go to OUT_Q with Q forced to all-ones, A = dividend, and divzero set.
  - Otherwise go to ITER.
- State ITER (one quotient bit per cycle):
  - Shift {A,Q} left by 1.
  - Compute T = A - M at BUS_WIDTH+1 bits.
  - If T ≥ 0: A=T and Q[0]=1. Otherwise A is unchanged (restored) and Q[0]=0.
  - Decrement the counter; when it reaches 0, go to FIX.
- State FIX:
  - Sign correction (see Optional Feature).
  - Without the feature, a single pass-through cycle.
  - Go to OUT_Q.
- State OUT_Q: outbus=Q (quotient), endsig=0; go to OUT_R.
- State OUT_R: outbus=A (remainder), endsig=1; go to IDLE.
- Latency, with no stalls and the start beat as cycle 0:
  - divisor captured at cycle 1
  - ITER at cycles 2..BUS_WIDTH+1
  - FIX at BUS_WIDTH+2
  - OUT_Q at BUS_WIDTH+3
  - OUT_R/endsig at BUS_WIDTH+4 (cycle 12 for BUS_WIDTH=8).
- Divide by zero skips ITER and FIX: OUT_Q at cycle 2, OUT_R at cycle 3.
- locksig=1 in any non-IDLE state freezes:
  - the state, registers and counter
  - the outbus/endsig/divzero values.
  
  In LOAD_M, inbus is captured only on a cycle where locksig=0. Every stall cycle delays completion by exactly one cycle.
- Other boundary rules:
  - beginsig while busy=1 is ignored.
  - A new start is accepted in the first IDLE cycle after OUT_R, giving 1-cycle turnaround.
  - Simultaneous rst and beginsig: rst wins.
- Arithmetic: all operands are unsigned BUS_WIDTH bits. Quotient and remainder satisfy dividend = Q·M + R with R < M.

Optional Feature:
- Macro: SIGNED_DIV_EN.
- Defined:
  - Operands are two's-complement.
  - LOAD_M records the sign of the dividend and the divisor, and converts both operands to their magnitudes (the magnitude of the most-negative value is its unsigned bit pattern).
  - FIX negates Q if the operand signs differ, and negates A if the dividend was negative.
  - Quotient truncates toward zero; the remainder takes the dividend's sign.
  - -2^(N-1) / -1 yields Q = -2^(N-1) (0x80 for N=8) and R=0, with no flag.
  - Divide by zero still gives Q=all-ones (-1) and R=dividend (original signed value).
- Undefined: unsigned operation only; FIX is a pass-through cycle.

Test Plan:
- Unsigned: dividend 100 (0x64), divisor 7 → OUT_Q outbus=0x0E, OUT_R outbus=0x02 with endsig=1 at cycle 12; busy high cycles 1–12.
- Divide by zero: 0x55/0x00 → outbus=0xFF, then 0x55 with endsig at cycle 3; divzero=1 in both beats.
- Stall: 200/9 with locksig=1 for 3 cycles mid-ITER → results 0x16/0x02, endsig at cycle 15; outbus frozen during any stalled OUT_Q.
- Reset mid-ITER (cycle 5) → next cycle busy=0, outbus=0. Then 255/16 → 0x0F/0x0F at cycle 12 relative to the new start.
- Ignored start and back-to-back: beginsig pulsed at cycle 6 has no effect. Start at cycle 13 with 9/3 → 0x03/0x00 at cycle 25.
- SIGNED_DIV_EN: -7/2 (0xF9/0x02) → 0xFD/0xFF; -128/-1 (0x80/0xFF) → 0x80/0x00; 7/-2 → 0xFD/0x01.
